ppt_pulse_sequencer: RTL
========================

// Module: ppt_pulse_sequencer
// PURPOSE
//  Pulse-train sequencing core behind the I2C register file of the PPT controller.
//  Takes PERIOD/WIDTH/COUNT/RUN from the register file and drives the pulse output.
//  Produces exactly COUNT pulses of WIDTH clocks each, repeated every PERIOD clocks.
//  Returns COUNT_DONE and DONE status for readback. Runs on the 32.768 kHz system clock.
// PARAMETERS
//  CNT_W   16   width of period/width/count operands and of all internal counters
// PORTS
//  clk           in   1      system clock (32.768 kHz); only clock
//  rst_n         in   1      asynchronous active-low reset
//  ena           in   1      design enable; 0 = hold all state (freeze)
//  run_i         in   1      RUN register bit, level; rising edge starts, falling edge aborts
//  period_i      in   CNT_W  pulse period in clk cycles (PERIOD_H:PERIOD_L)
//  width_i       in   CNT_W  high time in clk cycles (WIDTH_H:WIDTH_L)
//  count_i       in   CNT_W  number of pulses in the train (COUNT_H:COUNT_L)
//  pulse_o       out  1      pulse output, registered
//  busy_o        out  1      train in progress
//  done_o        out  1      sticky: the last train completed all COUNT pulses
//  count_done_o  out  CNT_W  completed pulses in the current or last train
//  cfg_err_o     out  1      sticky: the last start was rejected for bad configuration
// BEHAVIOUR
//  Reset: pulse_o=0, busy_o=0, done_o=0, count_done_o=0, cfg_err_o=0, state=IDLE, run_q=0.
//  ena=0: no state, counter, output or run_q update. Edges of run_i are evaluated only while ena=1.
//  start = ena & run_i & ~run_q, where run_q is run_i registered on ena.
//  States: IDLE, RUN, DONE.
//  On start, the block captures period/width/count into shadow registers.
//    Later input changes have no effect until the next start.
//  Start validity check: period>=2, 1<=width<period, count!=0.
//    Invalid: cfg_err_o<=1, done_o<=0, count_done_o<=0; the block stays in IDLE and pulse_o stays 0.
//    Valid: cfg_err_o<=0, done_o<=0, count_done_o<=0, busy_o<=1, phase<=0, pulse_o<=1.
//    The next state is RUN.
//  Latency: pulse_o rises on the same edge that first samples run_i=1.
//  RUN: phase counts 0..period-1; pulse_o=1 for phase<width and 0 otherwise.
//    pulse_o is registered from the next phase value.
//    At phase==period-1, phase wraps to 0 and count_done_o increments.
//    Exact high time = width cycles. Exact period = period cycles.
//  Completion: when an increment makes count_done_o==count, state goes to DONE on that edge.
//    On the same edge: pulse_o=0, busy_o=0, done_o=1.
//    Total train length = count*period cycles from the start edge.
//  DONE: outputs hold. The block returns to IDLE when run_i falls.
//    A new train needs a 0->1 on run_i; keeping run_i high does not retrigger.
//  Abort: run_i sampled 0 in RUN -> IDLE on that edge. pulse_o<=0, busy_o<=0, done_o stays 0.
//    count_done_o holds the partial count.
//  Abort on the completion edge: completion has priority, so done_o=1.
//  count_done_o never exceeds count.
//    The phase counter and the count counter are CNT_W bits wide and never wrap.
//  Async reset mid-train: immediate return to the reset values. No pulse after reset until a new rising edge.
// TESTING
//  1 Reset: assert rst_n=0 mid-pulse.
//    -> pulse_o, busy_o, done_o, cfg_err_o = 0 and count_done_o = 0 immediately.
//  2 Nominal: period=32, width=4, count=50, then run 0->1.
//    -> 50 pulses, each 4 cycles high and 28 low.
//    -> done_o=1 and busy_o=0 exactly 1600 cycles after start; count_done_o=50.
//  3 Abort: same configuration, drop run_i after 10 complete pulses plus 2 cycles.
//    -> pulse_o=0 on the sampling edge, count_done_o=10, done_o=0, busy_o=0.
//  4 Invalid configuration: width=0, then width=32 with period=32, then count=0.
//    -> cfg_err_o=1 each time with no pulse.
//    -> A following valid start clears cfg_err_o.
//  5 Shadowing and retrigger: change period to 8 mid-train.
//    -> The train keeps a period of 32.
//    -> run_i held high after done -> no new pulses.
//    -> run_i 1->0->1 starts a new train with period 8 and count_done_o reset to 0.
//  6 Freeze and edges: ena=0 for 20 cycles mid-pulse -> all outputs hold and the train resumes intact.
//    Also use period=2, width=1, count=1 -> one 1-cycle pulse, then done after 2 cycles.

Source files
------------

// File: rtl/ppt_pulse_sequencer.sv
// Pulse-train sequencer: emits COUNT pulses of WIDTH clocks every PERIOD clocks after a RUN rising edge.
// Configuration is shadowed at start; status (done/count/config error) is held for register readback.
module ppt_pulse_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             run_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [CNT_W-1:0] count_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_done_o,
    output logic             cfg_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    logic [1:0]       state_reg;
    logic             run_q_reg;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] width_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] phase_reg;
    logic [CNT_W-1:0] count_done_reg;
    logic             pulse_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             cfg_err_reg;

    logic             start;
    logic             cfg_ok;
    logic             wrap;
    logic [CNT_W-1:0] phase_next;
    logic [CNT_W-1:0] count_next;

    assign start      = run_i & ~run_q_reg;
    assign cfg_ok     = (period_i >= TWO) && (width_i != '0) &&
                        (width_i < period_i) && (count_i != '0);
    assign wrap       = (phase_reg == (period_reg - ONE));
    assign phase_next = wrap ? '0 : (phase_reg + ONE);
    assign count_next = count_done_reg + ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            run_q_reg      <= 1'b0;
            period_reg     <= '0;
            width_reg      <= '0;
            count_reg      <= '0;
            phase_reg      <= '0;
            count_done_reg <= '0;
            pulse_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            cfg_err_reg    <= 1'b0;
        end else if (ena) begin
            run_q_reg <= run_i;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        period_reg     <= period_i;
                        width_reg      <= width_i;
                        count_reg      <= count_i;
                        done_reg       <= 1'b0;
                        count_done_reg <= '0;
                        if (cfg_ok) begin
                            cfg_err_reg <= 1'b0;
                            busy_reg    <= 1'b1;
                            phase_reg   <= '0;
                            pulse_reg   <= 1'b1;
                            state_reg   <= ST_RUN;
                        end else begin
                            cfg_err_reg <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // Completion outranks an abort sampled on the same edge.
                    if (wrap && (count_next == count_reg)) begin
                        count_done_reg <= count_next;
                        phase_reg      <= '0;
                        pulse_reg      <= 1'b0;
                        busy_reg       <= 1'b0;
                        done_reg       <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else if (!run_i) begin
                        pulse_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        phase_reg <= phase_next;
                        pulse_reg <= (phase_next < width_reg);
                        if (wrap) begin
                            count_done_reg <= count_next;
                        end
                    end
                end
                ST_DONE: begin
                    if (!run_i) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign pulse_o      = pulse_reg;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;
    assign count_done_o = count_done_reg;
    assign cfg_err_o    = cfg_err_reg;

endmodule
